// File: rtl/dac_spi_rx.sv
// dac_spi_rx: sysclk-domain receiver for a 16-bit SPI DAC command stream.
// Serial inputs are oversampled by sysclk, frames are framed by dac_cs and
// committed to the modelled DAC output by a dac_ld falling edge.
// Optional feature macro: DAC_SPI_RX_SHDN_EN (SHDN_n == 0 loads force 0).
module dac_spi_rx #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       sck,
  input  logic       sdi,
  input  logic       dac_cs,
  input  logic       dac_ld,
  output logic [9:0] frame_data,
  output logic [3:0] frame_cfg,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [9:0] dac_value,
  output logic       ld_strobe,
  output logic       busy
);

  localparam int unsigned SR_W   = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned CFG_W  = 4;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(16);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(17);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, cs_sync, ld_sync;
  logic                   sck_q, cs_q, ld_q;
  logic                   sck_s, sdi_s, cs_s, ld_s;
  logic                   sck_rise, cs_fall, cs_rise, ld_fall;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [SR_W-1:0]        sr, sr_n;
  logic [DATA_W-1:0]      frame_data_n, dac_value_n, load_value;
  logic [CFG_W-1:0]       frame_cfg_n;
  logic                   frame_valid_n, frame_err_n, ld_strobe_n;

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign ld_s  = ld_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_q;
  assign cs_fall  = ~cs_s & cs_q;
  assign cs_rise  = cs_s & ~cs_q;
  assign ld_fall  = ~ld_s & ld_q;

  // Value written to the DAC on a load; shutdown forces zero when enabled.
`ifdef DAC_SPI_RX_SHDN_EN
  assign load_value = frame_cfg[0] ? frame_data : '0;
`else
  assign load_value = frame_data;
`endif

  // Input synchronisers plus one delayed copy for edge detection, reset to idle levels.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_sync  <= '1;
      ld_sync  <= '1;
      sck_q    <= 1'b0;
      cs_q     <= 1'b1;
      ld_q     <= 1'b1;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], dac_cs};
      ld_sync  <= {ld_sync[SYNC_STAGES-2:0], dac_ld};
      sck_q    <= sck_s;
      cs_q     <= cs_s;
      ld_q     <= ld_s;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      frame_data  <= '0;
      frame_cfg   <= '0;
      dac_value   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      ld_strobe   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sr          <= sr_n;
      frame_data  <= frame_data_n;
      frame_cfg   <= frame_cfg_n;
      dac_value   <= dac_value_n;
      frame_valid <= frame_valid_n;
      frame_err   <= frame_err_n;
      ld_strobe   <= ld_strobe_n;
      busy        <= (state_n == SHIFT);
    end
  end

  // Next-state and next-output logic; a load in HOLD wins over a new frame start.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    sr_n          = sr;
    frame_data_n  = frame_data;
    frame_cfg_n   = frame_cfg;
    dac_value_n   = dac_value;
    frame_valid_n = 1'b0;
    frame_err_n   = 1'b0;
    ld_strobe_n   = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_n = SHIFT;
          cnt_n   = '0;
          sr_n    = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (cnt == CNT_FULL) begin
            state_n       = HOLD;
            frame_data_n  = sr[11:2];
            frame_cfg_n   = sr[15:12];
            frame_valid_n = 1'b1;
          end else begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
          end
        end else if (sck_rise) begin
          sr_n  = {sr[SR_W-2:0], sdi_s};
          cnt_n = (cnt == CNT_SAT) ? CNT_SAT : cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (ld_fall) begin
          dac_value_n = load_value;
          ld_strobe_n = 1'b1;
          if (cs_fall) begin
            state_n = SHIFT;
            cnt_n   = '0;
            sr_n    = '0;
          end else begin
            state_n = IDLE;
          end
        end else if (cs_fall) begin
          state_n     = SHIFT;
          cnt_n       = '0;
          sr_n        = '0;
          frame_err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_rx.sv
// tb_dac_spi_rx: directed self-checking bench for dac_spi_rx.
// Honours DAC_SPI_RX_SHDN_EN for the shutdown-load expectation.
module tb_dac_spi_rx;

  localparam int unsigned HALF = 4;   // sysclk cycles per sck half period

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       sck    = 1'b0;
  logic       sdi    = 1'b0;
  logic       dac_cs = 1'b1;
  logic       dac_ld = 1'b1;
  logic [9:0] frame_data;
  logic [3:0] frame_cfg;
  logic       frame_valid;
  logic       frame_err;
  logic [9:0] dac_value;
  logic       ld_strobe;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int fv_total = 0;
  int fe_total = 0;
  int ld_total = 0;
  int fv_base, fe_base, ld_base;
  logic busy_mid;
  logic [9:0] sample;

  dac_spi_rx #(.SYNC_STAGES(2)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .sck         (sck),
    .sdi         (sdi),
    .dac_cs      (dac_cs),
    .dac_ld      (dac_ld),
    .frame_data  (frame_data),
    .frame_cfg   (frame_cfg),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .dac_value   (dac_value),
    .ld_strobe   (ld_strobe),
    .busy        (busy)
  );

  always #10 sysclk = ~sysclk;

  // Pulse counters, sampled away from the active edge.
  always @(negedge sysclk) begin
    if (frame_valid) fv_total <= fv_total + 1;
    if (frame_err)   fe_total <= fe_total + 1;
    if (ld_strobe)   ld_total <= ld_total + 1;
  end

  initial begin
    #50ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic mark();
    wait_cyc(1);
    fv_base = fv_total;
    fe_base = fe_total;
    ld_base = ld_total;
  endtask

  // Clocks nbits MSB-first from w (zeros beyond 16), framed by dac_cs.
  task automatic send_frame(input logic [15:0] w, input int nbits, input bit ld_with_cs);
    logic [15:0] sh;
    sh = w;
    dac_cs = 1'b0;
    if (ld_with_cs) dac_ld = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      sdi = sh[15];
      sh  = {sh[14:0], 1'b0};
      wait_cyc(HALF);
      sck = 1'b1;
      wait_cyc(HALF);
      sck = 1'b0;
      if (i == nbits / 2) busy_mid = busy;
    end
    dac_ld = 1'b1;
    wait_cyc(HALF);
    dac_cs = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic load_dac();
    wait_cyc(2 * HALF);
    dac_ld = 1'b0;
    wait_cyc(2 * HALF);
    dac_ld = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  initial begin
    // Reset state
    wait_cyc(3);
    check("rst_frame_data", 32'(frame_data), 32'h0);
    check("rst_frame_cfg", 32'(frame_cfg), 32'h0);
    check("rst_dac_value", 32'(dac_value), 32'h0);
    check("rst_pulses", 32'({frame_valid, frame_err, ld_strobe}), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    wait_cyc(4);

    // Full-scale frame then load
    mark();
    send_frame(16'h3FFC, 16, 1'b0);
    check("ff_busy_mid", 32'(busy_mid), 32'h1);
    check("ff_valid_cnt", 32'(fv_total - fv_base), 32'd1);
    check("ff_data", 32'(frame_data), 32'h3FF);
    check("ff_cfg", 32'(frame_cfg), 32'h3);
    check("ff_hold_busy", 32'(busy), 32'h0);
    check("ff_dac_preload", 32'(dac_value), 32'h0);
    load_dac();
    check("ff_ld_cnt", 32'(ld_total - ld_base), 32'd1);
    check("ff_dac", 32'(dac_value), 32'h3FF);
    check("ff_err_cnt", 32'(fe_total - fe_base), 32'd0);

    // Short frame, then load ignored in IDLE
    mark();
    send_frame(16'hABCD, 12, 1'b0);
    check("short_err_cnt", 32'(fe_total - fe_base), 32'd1);
    check("short_valid_cnt", 32'(fv_total - fv_base), 32'd0);
    check("short_busy", 32'(busy), 32'h0);
    check("short_data", 32'(frame_data), 32'h3FF);
    load_dac();
    check("idle_ld_cnt", 32'(ld_total - ld_base), 32'd0);
    check("short_dac", 32'(dac_value), 32'h3FF);

    // Long frame (18 edges)
    mark();
    send_frame(16'h1234, 18, 1'b0);
    check("long_err_cnt", 32'(fe_total - fe_base), 32'd1);
    check("long_valid_cnt", 32'(fv_total - fv_base), 32'd0);
    check("long_busy", 32'(busy), 32'h0);
    check("long_data", 32'(frame_data), 32'h3FF);
    check("long_dac", 32'(dac_value), 32'h3FF);

    // Pending frame discarded by a new dac_cs fall
    mark();
    send_frame(16'h3200, 16, 1'b0);
    check("disc_first_data", 32'(frame_data), 32'h080);
    send_frame(16'h3004, 16, 1'b0);
    check("disc_err_cnt", 32'(fe_total - fe_base), 32'd1);
    check("disc_valid_cnt", 32'(fv_total - fv_base), 32'd2);
    check("disc_dac_kept", 32'(dac_value), 32'h3FF);
    check("disc_ld_cnt", 32'(ld_total - ld_base), 32'd0);
    load_dac();
    check("disc_dac", 32'(dac_value), 32'h001);

    // Shutdown bit clear on load
    mark();
    send_frame(16'h2FFC, 16, 1'b0);
    check("shdn_cfg", 32'(frame_cfg), 32'h2);
    load_dac();
    check("shdn_ld_cnt", 32'(ld_total - ld_base), 32'd1);
`ifdef DAC_SPI_RX_SHDN_EN
    check("shdn_dac", 32'(dac_value), 32'h000);
`else
    check("shdn_dac", 32'(dac_value), 32'h3FF);
`endif

    // Simultaneous dac_cs and dac_ld falls in HOLD: load, then capture next frame
    mark();
    send_frame(16'h3A5C, 16, 1'b0);
    check("sim_first_data", 32'(frame_data), 32'h297);
    send_frame(16'h3124, 16, 1'b1);
    check("sim_ld_cnt", 32'(ld_total - ld_base), 32'd1);
    check("sim_err_cnt", 32'(fe_total - fe_base), 32'd0);
    check("sim_busy_mid", 32'(busy_mid), 32'h1);
    check("sim_dac", 32'(dac_value), 32'h297);
    check("sim_valid_cnt", 32'(fv_total - fv_base), 32'd2);
    check("sim_second_data", 32'(frame_data), 32'h049);
    load_dac();
    check("sim_dac2", 32'(dac_value), 32'h049);

    // Reset mid-frame after 8 sck edges
    mark();
    dac_cs = 1'b0;
    sdi    = 1'b1;
    wait_cyc(HALF);
    for (int i = 0; i < 8; i++) begin
      wait_cyc(HALF);
      sck = 1'b1;
      wait_cyc(HALF);
      sck = 1'b0;
    end
    busy_mid = busy;
    reset = 1'b1;
    wait_cyc(1);
    check("mid_busy_before", 32'(busy_mid), 32'h1);
    check("mid_rst_outputs", 32'({frame_data, frame_cfg, dac_value}), 32'h0);
    check("mid_rst_flags", 32'({frame_valid, frame_err, ld_strobe, busy}), 32'h0);
    reset  = 1'b0;
    dac_cs = 1'b1;
    sdi    = 1'b0;
    wait_cyc(4 * HALF);
    check("mid_no_pulse", 32'((fv_total - fv_base) + (fe_total - fe_base) + (ld_total - ld_base)), 32'd0);
    check("mid_idle_busy", 32'(busy), 32'h0);
    send_frame(16'h3554, 16, 1'b0);
    load_dac();
    check("mid_dac", 32'(dac_value), 32'h155);

    // Back-to-back random samples
    mark();
    for (int k = 0; k < 40; k++) begin
      sample = 10'($urandom_range(0, 1023));
      send_frame({4'h3, sample, 2'b00}, 16, 1'b0);
      load_dac();
      check("stream_dac", 32'(dac_value), 32'(sample));
    end
    check("stream_err_cnt", 32'(fe_total - fe_base), 32'd0);
    check("stream_ld_cnt", 32'(ld_total - ld_base), 32'd40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dac_spi_rx.md
DAC_SPI_RX -- requirements
Module: dac_spi_rx

Interface
REQ-001 The block SHALL expose parameter SYNC_STAGES, default 2: number of sysclk flops synchronising sck, sdi, dac_cs and dac_ld (legal 2..3).
REQ-002 The block SHALL have these ports (one per line: name, direction, width, meaning):
- sysclk  in  1  single system clock (50 MHz); all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- sck  in  1  serial clock from the SPI DAC master
- sdi  in  1  serial data, MSB first
- dac_cs  in  1  chip select, active low
- dac_ld  in  1  load strobe, active low
- frame_data  out  10  data bits [11:2] of the last good frame
- frame_cfg  out  4  bits [15:12] of the last good frame (A/B, BUF, GA_n, SHDN_n)
- frame_valid  out  1  one-cycle pulse, good frame captured
- frame_err  out  1  one-cycle pulse, malformed frame
- dac_value  out  10  value presented by the modelled DAC
- ld_strobe  out  1  one-cycle pulse, dac_value updated
- busy  out  1  high while in SHIFT

Function
REQ-003 All four serial inputs SHALL pass through SYNC_STAGES flops; edges SHALL be detected on synchronised signals only; sck frequency SHALL be at most sysclk/4.
REQ-004 FSM states: IDLE, SHIFT, HOLD.
REQ-005 IDLE -> SHIFT on synchronised dac_cs falling edge; bit counter cleared to 0; shift register cleared.
REQ-006 In SHIFT, each synchronised sck rising edge SHALL shift sdi into bit 0 of a 16-bit shift register and increment a 5-bit counter, saturating at 17.
REQ-007 SHIFT, dac_cs rising with count == 16 -> HOLD; same cycle latch frame_data = sr[11:2] and frame_cfg = sr[15:12]; frame_valid pulses the next cycle.
REQ-008 SHIFT, dac_cs rising with count != 16 (short or >16 edges) -> IDLE; frame_err pulses one cycle; frame_data and frame_cfg unchanged.
REQ-009 HOLD, synchronised dac_ld falling edge -> IDLE; dac_value updated from frame_data (subject to REQ-015); ld_strobe pulses one cycle.
REQ-010 HOLD, dac_cs falling before dac_ld -> SHIFT; pending frame discarded (dac_value unchanged); frame_err pulses one cycle.
REQ-011 dac_ld falling in IDLE or SHIFT SHALL be ignored; no ld_strobe.
REQ-012 Simultaneous dac_cs and dac_ld falling edges in HOLD: load SHALL win (REQ-009), then the FSM SHALL enter SHIFT in the same transition so the new frame is captured.
REQ-013 sck edges while dac_cs is high SHALL have no effect; busy = (state == SHIFT).

Reset
REQ-014 While reset is high at a sysclk edge: state IDLE, counter 0, shift register 0, sync flops set to idle levels (sck 0, sdi 0, dac_cs 1, dac_ld 1), frame_data 0, frame_cfg 0, dac_value 0, frame_valid/frame_err/ld_strobe/busy 0; reset mid-frame SHALL abort with no pulse.

Configuration
REQ-015 Macro DAC_SPI_RX_SHDN_EN: when defined, a load with frame_cfg[0] (SHDN_n) == 0 SHALL set dac_value to 0 while ld_strobe still pulses; when undefined, SHDN_n is ignored and dac_value = frame_data on every load.

Verification
REQ-016 Frame 16'h3FFC (cfg 4'h3, data 10'h3FF), dac_ld low 2 sck periods after dac_cs high -> frame_valid once, frame_data 10'h3FF, then ld_strobe once, dac_value 10'h3FF.
REQ-017 dac_cs low, 12 sck edges, dac_cs high -> frame_err once, state IDLE, frame_data/dac_value unchanged; repeat with 18 edges -> same response.
REQ-018 Good frame 16'h3200 then second dac_cs falling before dac_ld, second frame 16'h3004 + dac_ld -> frame_err once, then dac_value 10'h001.
REQ-019 Frame 16'h2FFC + dac_ld -> dac_value 10'h000 with DAC_SPI_RX_SHDN_EN defined, 10'h3FF without; ld_strobe pulses in both builds.
REQ-020 reset high for 1 cycle after 8 sck edges -> all outputs 0, busy 0; a following full frame 16'h3554 + dac_ld -> dac_value 10'h155.
REQ-021 Back-to-back run through the codebase SPI DAC master at 10 kHz, 1000 random 10-bit samples -> every dac_value matches the sample sent, zero frame_err.
